id_fetch_ctrl: RTL
==================

Name: id_fetch_ctrl

Overview:
- ID-side counterpart of the instruction-fetch stage: holds the IF/ID pipeline register, consumes the fetched Instruction and PC, and resolves branches and jumps in ID.
- Drives the fetch stage's Branch/Jump selects, BranchDest/JumpDest and PC WriteEnable.
- Detects operand hazards on branch/jr sources and load-use, stalls fetch, and squashes the wrong-path fetch when a redirect is taken.

Parameters:
DELAY_SLOT, 0, 1 = instruction after a taken branch/jump executes (no squash); 0 = it is squashed
CNT_W, 16, width of saturating stall/flush statistic counters

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-low reset
IF_Instruction  input  32  instruction fetched this cycle
IF_PC  input  32  PC of IF_Instruction
RsData  input  32  register-file/forwarded value of ID rs
RtData  input  32  register-file/forwarded value of ID rt
EX_RegWrite  input  1  instruction in EX writes a register
EX_MemRead  input  1  instruction in EX is a load
EX_WriteReg  input  5  destination register of EX instruction
MEM_MemRead  input  1  instruction in MEM is a load
MEM_WriteReg  input  5  destination register of MEM instruction
ID_Instruction  output  32  IF/ID register: instruction
ID_PCPlus4  output  32  IF/ID register: IF_PC+4
ID_Valid  output  1  IF/ID register holds a real instruction
ID_Bubble  output  1  insert NOP into ID/EX this cycle
PC_WriteEnable  output  1  to fetch-stage WriteEnable
Branch  output  1  taken conditional branch; fetch mux sel bit 0
Jump  output  1  j/jal/jr; fetch mux sel bit 1
BranchDest  output  32  branch target
JumpDest  output  32  jump target
StallCount  output  CNT_W  saturating count of stall cycles
FlushCount  output  CNT_W  saturating count of squashed fetches

Behaviour:
- Reset (Reset=0 at an edge): ID_Instruction=0 (NOP), ID_PCPlus4=0, ID_Valid=0, counters=0. While Reset=0: PC_WriteEnable=1, Branch=Jump=0, ID_Bubble=0. Reset mid-stall or mid-redirect discards all state at that edge.
- Decode (MIPS-I) of ID_Instruction: beq op=4, bne op=5, j op=2, jal op=3, jr op=0/funct=8. All other encodings are non-control.
- BranchDest = ID_PCPlus4 + (sign-extended imm16 << 2), mod 2^32; computed every cycle.
- JumpDest = RsData for jr; otherwise {ID_PCPlus4[31:28], instr[25:0], 2'b00}.
- Hazard (combinational, evaluated every cycle, only when ID_Valid). A source register is used and nonzero and matches one of:
  - EX_MemRead && EX_WriteReg, for any instruction using rs or rt (load-use);
  - EX_RegWrite && EX_WriteReg, for beq/bne (rs, rt) or jr (rs);
  - MEM_MemRead && MEM_WriteReg, for beq/bne/jr.
  - Register 0 never causes a hazard.
- Stall cycle (hazard=1):
  - PC_WriteEnable=0; IF/ID holds; ID_Bubble=1; Branch=Jump=0; StallCount++.
  - The condition re-evaluates each cycle, so a load feeding a beq stalls 2 cycles.
- Redirect (no hazard, ID_Valid):
  - Jump=1 for j/jal/jr.
  - Branch=1 for beq with RsData==RtData, or bne with RsData!=RtData.
  - Branch and Jump are never both 1; Jump has priority by construction (jumps are not branches).
- IF/ID update at each edge with no hazard:
  - If a redirect is taken and DELAY_SLOT=0: load NOP, ID_Valid=0, FlushCount++.
  - Otherwise: load IF_Instruction, IF_PC+4, ID_Valid=1.
- Stall and redirect in the same cycle: the stall wins; the redirect is issued on the first non-hazard cycle.
- Latency: a control instruction resolves in the cycle it sits in ID; the PC updates at the following edge.
- Counters saturate at all-ones.
- Non-control instructions never assert Branch or Jump. Not-taken branches assert neither.

Decomposition:
- Shared package:
  - opcode/funct constants (OP_BEQ, OP_BNE, OP_J, OP_JAL, FUNCT_JR);
  - NOP encoding;
  - fetch-mux select encoding {Jump,Branch}.
- One natural sub-module: id_hazard_detect (pure combinational hazard equations), instantiated once.
- The IF/ID register, redirect logic and counters stay in the top.

Test Plan:
- Reset held 3 cycles with IF_Instruction=0x8C010000 → ID_Instruction=0, ID_Valid=0, PC_WriteEnable=1, Branch=Jump=0; release → next edge ID_Instruction=0x8C010000.
- beq $1,$2,+4 at IF_PC=0x100, RsData=RtData=5, no hazard → Branch=1, BranchDest=0x114; next edge ID_Instruction=0, FlushCount=1 (DELAY_SLOT=0); with DELAY_SLOT=1 the next instruction loads and FlushCount=0.
- bne with RsData=RtData=7 → Branch=0, Jump=0; the next fetch loads normally.
- j 0x0000040 with ID_PCPlus4=0x10000008 → Jump=1, JumpDest=0x10000100; jr $31 with RsData=0x200 → JumpDest=0x200.
- Load-use: EX_MemRead=1, EX_WriteReg=3; ID add uses $3 → exactly one cycle of PC_WriteEnable=0 and ID_Bubble=1; IF/ID unchanged; StallCount=1.
- Load then beq on the load's register → 2 stall cycles (EX, then MEM match); Branch is asserted only in the 3rd cycle. Reset asserted during the stall → ID_Valid=0 and counters=0 at the next edge.

Source files
------------

// File: rtl/id_fetch_ctrl_pkg.sv
// Shared encodings for the ID-side fetch controller: MIPS-I control opcodes,
// the NOP word, the fetch-mux select and a small control decoder.
package id_fetch_ctrl_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'd0;
  localparam logic [5:0]  OP_J     = 6'd2;
  localparam logic [5:0]  OP_JAL   = 6'd3;
  localparam logic [5:0]  OP_BEQ   = 6'd4;
  localparam logic [5:0]  OP_BNE   = 6'd5;
  localparam logic [5:0]  FUNCT_JR = 6'h08;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // Fetch-stage PC mux select, packed as {Jump, Branch}.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10
  } fetch_sel_e;

  typedef struct packed {
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic is_jal;
    logic is_jr;
    logic uses_rs;
    logic uses_rt;
  } ctrl_dec_t;

  // Control-class decode plus which source fields are real operands.
  // Stores (op 101xxx) read rt; R-type reads rs/rt except jr (rs only).
  function automatic ctrl_dec_t decode_ctrl(input logic [31:0] instr);
    ctrl_dec_t  d;
    logic [5:0] op;
    op        = instr[31:26];
    d         = '0;
    d.is_beq  = (op == OP_BEQ);
    d.is_bne  = (op == OP_BNE);
    d.is_j    = (op == OP_J);
    d.is_jal  = (op == OP_JAL);
    d.is_jr   = (op == OP_RTYPE) && (instr[5:0] == FUNCT_JR);
    d.uses_rs = !(d.is_j || d.is_jal);
    d.uses_rt = ((op == OP_RTYPE) && !d.is_jr) || d.is_beq || d.is_bne ||
                (op[5:3] == 3'b101);
    return d;
  endfunction

endpackage

// File: rtl/id_fetch_ctrl_hazard.sv
// Combinational operand-hazard detection for the instruction held in ID.
module id_hazard_detect
  import id_fetch_ctrl_pkg::*;
(
  input  ctrl_dec_t  dec,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       id_valid,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_write_reg,
  output logic       hazard
);

  logic rs_ex, rt_ex, rs_mem, rt_mem, is_br;
  logic load_use, ex_ctrl, mem_ctrl;

  // Match used, nonzero sources against EX/MEM destinations and combine per rule.
  always_comb begin
    is_br    = dec.is_beq || dec.is_bne;
    rs_ex    = dec.uses_rs && (rs != 5'd0) && (rs == ex_write_reg);
    rt_ex    = dec.uses_rt && (rt != 5'd0) && (rt == ex_write_reg);
    rs_mem   = dec.uses_rs && (rs != 5'd0) && (rs == mem_write_reg);
    rt_mem   = dec.uses_rt && (rt != 5'd0) && (rt == mem_write_reg);
    load_use = ex_mem_read && (rs_ex || rt_ex);
    ex_ctrl  = ex_reg_write && ((is_br && (rs_ex || rt_ex)) || (dec.is_jr && rs_ex));
    mem_ctrl = mem_mem_read && ((is_br && (rs_mem || rt_mem)) || (dec.is_jr && rs_mem));
    hazard   = id_valid && (load_use || ex_ctrl || mem_ctrl);
  end

endmodule

// File: rtl/id_fetch_ctrl.sv
// ID-stage fetch controller: IF/ID register, branch/jump resolution,
// hazard stalls, wrong-path squash and saturating statistics.
module id_fetch_ctrl
  import id_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DELAY_SLOT = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IF_Instruction,
  input  logic [31:0]      IF_PC,
  input  logic [31:0]      RsData,
  input  logic [31:0]      RtData,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_WriteReg,
  output logic [31:0]      ID_Instruction,
  output logic [31:0]      ID_PCPlus4,
  output logic             ID_Valid,
  output logic             ID_Bubble,
  output logic             PC_WriteEnable,
  output logic             Branch,
  output logic             Jump,
  output logic [31:0]      BranchDest,
  output logic [31:0]      JumpDest,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [31:0]      id_instr_q, id_instr_d;
  logic [31:0]      id_pc4_q,   id_pc4_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  ctrl_dec_t  dec;
  fetch_sel_e sel;
  logic       hazard, stall, taken;

  assign dec = decode_ctrl(id_instr_q);

  id_hazard_detect u_hazard (
    .dec          (dec),
    .rs           (id_instr_q[25:21]),
    .rt           (id_instr_q[20:16]),
    .id_valid     (id_valid_q),
    .ex_reg_write (EX_RegWrite),
    .ex_mem_read  (EX_MemRead),
    .ex_write_reg (EX_WriteReg),
    .mem_mem_read (MEM_MemRead),
    .mem_write_reg(MEM_WriteReg),
    .hazard       (hazard)
  );

  // Branch/jump targets, computed every cycle regardless of instruction class.
  always_comb begin
    BranchDest = id_pc4_q + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    JumpDest   = dec.is_jr ? RsData : {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
  end

  // Redirect resolution; everything is forced quiet while Reset is low.
  always_comb begin
    sel   = SEL_SEQ;
    stall = Reset && hazard;
    if (Reset && id_valid_q && !hazard) begin
      if (dec.is_j || dec.is_jal || dec.is_jr)
        sel = SEL_JUMP;
      else if ((dec.is_beq && (RsData == RtData)) || (dec.is_bne && (RsData != RtData)))
        sel = SEL_BRANCH;
    end
    taken          = (sel != SEL_SEQ);
    Jump           = (sel == SEL_JUMP);
    Branch         = (sel == SEL_BRANCH);
    PC_WriteEnable = !stall;
    ID_Bubble      = stall;
  end

  // IF/ID next state: hold on stall, squash on redirect without delay slot.
  always_comb begin
    id_instr_d  = id_instr_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (taken && (DELAY_SLOT == 0)) begin
      id_instr_d = NOP;
      id_pc4_d   = '0;
      id_valid_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      id_instr_d = IF_Instruction;
      id_pc4_d   = IF_PC + 32'd4;
      id_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      id_instr_q  <= NOP;
      id_pc4_q    <= '0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_instr_q  <= id_instr_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_Instruction = id_instr_q;
  assign ID_PCPlus4     = id_pc4_q;
  assign ID_Valid       = id_valid_q;
  assign StallCount     = stall_cnt_q;
  assign FlushCount     = flush_cnt_q;

endmodule
